// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if : byte-wide memory-controller port used by the fetch stage.
//
//   mem_req   fetch -> mem   byte read request
//   mem_addr  fetch -> mem   byte address of the request
//   mem_gnt   mem -> fetch   arbiter accepts the request this cycle
//   mem_valid mem -> fetch   requested byte returned this cycle
//   mem_rdata mem -> fetch   returned byte
//
// modport master : fetch-stage side
// modport slave  : memory-controller side
// ---------------------------------------------------------------------------
interface if_fetch_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_valid;
   logic [7:0]  mem_rdata;

   modport master (output mem_req, mem_addr,
                   input  mem_gnt, mem_valid, mem_rdata);

   modport slave  (input  mem_req, mem_addr,
                   output mem_gnt, mem_valid, mem_rdata);
endinterface : if_fetch_if

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch : instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the architectural PC and builds each 32-bit instruction from four
// little-endian byte reads (pc+0 .. pc+3), one outstanding at a time.
//
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   rdy          global ready; 0 freezes every register
//   stall[4:0]   pipeline stall vector; stall[1]=1 means IF/ID holds
//   use_npc      redirect request from decode
//   npc_addr     redirect target (no alignment check)
//   mem          byte-wide memory port (if_fetch_if.master)
//   stallreq_if  1 while the instruction is not yet assembled
//   if_pc        PC of the presented instruction (0 while fetching)
//   if_inst      presented instruction (0 = bubble)
// ---------------------------------------------------------------------------
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic [4:0]        stall,
   input  logic              use_npc,
   input  logic [31:0]       npc_addr,
   if_fetch_if.master        mem,
   output logic              stallreq_if,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_inst
);

   typedef enum logic {
      FETCH = 1'b0,
      DONE  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [1:0]      k_q, k_d;        // index of the byte being fetched
   logic [3:0][7:0] inst_q, inst_d;  // assembly buffer, byte k at [k]
   logic            pend_q, pend_d;  // a granted byte has not returned yet
   logic            drain_q, drain_d;// the pending byte belongs to a stale PC
   logic            req_q, req_d;
   logic [31:0]     addr_q, addr_d;

   logic redirect;
   logic granted;
   logic returned;

   // Only stall[1] concerns this stage.
   logic unused_stall;
   assign unused_stall = ^{stall[4:2], stall[0]};

   assign redirect = use_npc & ~stall[1];
   assign granted  = req_q & mem.mem_gnt;
   // A return is only meaningful while a byte is outstanding.
   assign returned = pend_q & mem.mem_valid;

   // NOTE: every variable gets its hold value first so no path through the
   // block leaves one unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      k_d     = k_q;
      inst_d  = inst_q;
      pend_d  = pend_q;
      drain_d = drain_q;
      addr_d  = addr_q;

      if (granted) begin
         pend_d = 1'b1;
      end
      if (returned) begin
         pend_d  = 1'b0;
         drain_d = 1'b0;
      end

      unique case (state_q)
         FETCH: begin
            if (returned && !drain_q) begin
               inst_d[k_q] = mem.mem_rdata;
               k_d         = k_q + 2'd1;
               if (k_q == 2'd3) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (!stall[1]) begin
               pc_d    = pc_q + 32'd4;
               k_d     = 2'd0;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      // Redirect overrides consume and any byte captured this cycle. A byte
      // still in flight afterwards (including one granted right now) must be
      // swallowed before the new fetch may issue.
      if (redirect) begin
         pc_d    = npc_addr;
         k_d     = 2'd0;
         inst_d  = '0;
         state_d = FETCH;
         drain_d = pend_d;
      end

      // drain implies pend, so pend alone gates new requests.
      req_d = (state_d == FETCH) && !pend_d;
      if (req_d) begin
         addr_d = pc_d + {30'd0, k_d};
      end
   end

   // NOTE: non-blocking assignments so every register samples the values
   // computed before this edge, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         k_q     <= 2'd0;
         // NOTE: the assembly buffer is reset too; it is small and drives
         // if_inst, so it must never expose X after reset.
         inst_q  <= '0;
         pend_q  <= 1'b0;
         drain_q <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= 32'd0;
      end else if (rdy) begin
         state_q <= state_d;
         pc_q    <= pc_d;
         k_q     <= k_d;
         inst_q  <= inst_d;
         pend_q  <= pend_d;
         drain_q <= drain_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
      end
   end

   assign mem.mem_req  = req_q;
   assign mem.mem_addr = addr_q;

   assign stallreq_if = (state_q != DONE);
   assign if_pc       = (state_q == DONE) ? pc_q   : 32'd0;
   assign if_inst     = (state_q == DONE) ? inst_q : 32'd0;

endmodule : if_fetch

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch : randomized self-checking bench for if_fetch.
// The reference model is the sequence of PCs the pipeline should see; each
// expected instruction is read from a behavioural byte memory.
// ---------------------------------------------------------------------------
module tb_if_fetch;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // main DUT (RESET_PC = 0)
   logic        rst_n;
   logic        rdy;
   logic [4:0]  stall;
   logic        use_npc;
   logic [31:0] npc_addr;
   logic        stallreq_if;
   logic [31:0] if_pc, if_inst;
   if_fetch_if  bus ();

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst_n), .rdy(rdy), .stall(stall), .use_npc(use_npc),
      .npc_addr(npc_addr), .mem(bus), .stallreq_if(stallreq_if),
      .if_pc(if_pc), .if_inst(if_inst));

   // wrap DUT (RESET_PC = 0xFFFFFFFC), free-running consume
   logic        w_rst_n;
   logic        w_stallreq;
   logic [31:0] w_pc, w_inst;
   if_fetch_if  w_bus ();

   if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(w_rst_n), .rdy(1'b1), .stall(5'b0), .use_npc(1'b0),
      .npc_addr(32'h0), .mem(w_bus), .stallreq_if(w_stallreq),
      .if_pc(w_pc), .if_inst(w_inst));

   int n_checks = 0;
   int n_fail   = 0;
   int n_presented = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural memory
   function automatic logic [7:0] mb(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'd0: return 8'h13;
         32'd1: return 8'h05;
         32'd2: return 8'h10;
         32'd3: return 8'h00;
         default: begin
            h = a * 32'h9E37_79B1;
            return h[31:24] ^ h[7:0];
         end
      endcase
   endfunction

   function automatic exp_t mk(input logic [31:0] p);
      exp_t e;
      e.pc   = p;
      e.inst = {mb(p + 32'd3), mb(p + 32'd2), mb(p + 32'd1), mb(p)};
      return e;
   endfunction

   exp_t        sb_q[$];
   exp_t        w_q[$];
   logic [31:0] model_pc;
   logic [31:0] grant_log[$];
   logic [31:0] w_log[$];

   // ---------------- memory responder, main DUT ----------------
   bit          rand_mode = 0;
   int          fixed_lat = 1;
   bit          pending   = 0;
   int          lat_cnt   = 0;
   logic [31:0] p_addr;

   initial begin
      bus.mem_gnt = 1'b0; bus.mem_valid = 1'b0; bus.mem_rdata = 8'h00;
      forever begin
         @(posedge clk); #2;
         bus.mem_valid = 1'b0;
         bus.mem_gnt   = 1'b0;
         if (!rst_n) begin
            pending = 0;
         end else if (!rdy) begin
            // junk that a frozen fetch stage must ignore
            bus.mem_valid = 1'b1;
            bus.mem_rdata = 8'hEE;
            bus.mem_gnt   = 1'b1;
         end else begin
            if (bus.mem_req) check("one_outstanding", {31'd0, pending}, 32'd0);
            if (pending) begin
               if (lat_cnt == 0) begin
                  bus.mem_valid = 1'b1;
                  bus.mem_rdata = mb(p_addr);
                  pending       = 0;
               end else begin
                  lat_cnt--;
               end
            end else if (bus.mem_req && (!rand_mode || $urandom_range(1, 0) == 1)) begin
               bus.mem_gnt = 1'b1;
               pending     = 1;
               p_addr      = bus.mem_addr;
               lat_cnt     = (rand_mode ? int'($urandom_range(3, 1)) : fixed_lat) - 1;
               grant_log.push_back(p_addr);
            end else if (rand_mode && $urandom_range(7, 0) == 0) begin
               bus.mem_valid = 1'b1;
               bus.mem_rdata = 8'($urandom);
            end
         end
      end
   end

   // ---------------- memory responder, wrap DUT ----------------
   bit          w_pend = 0;
   logic [31:0] w_addr;

   initial begin
      w_bus.mem_gnt = 1'b0; w_bus.mem_valid = 1'b0; w_bus.mem_rdata = 8'h00;
      forever begin
         @(posedge clk); #2;
         w_bus.mem_valid = 1'b0;
         w_bus.mem_gnt   = 1'b0;
         if (!w_rst_n) begin
            w_pend = 0;
         end else if (w_pend) begin
            w_bus.mem_valid = 1'b1;
            w_bus.mem_rdata = mb(w_addr);
            w_pend = 0;
         end else if (w_bus.mem_req) begin
            w_bus.mem_gnt = 1'b1;
            w_pend = 1;
            w_addr = w_bus.mem_addr;
            w_log.push_back(w_addr);
         end
      end
   end

   // ---------------- monitors ----------------
   logic prev_sr = 1'b1;
   exp_t mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_sr = 1'b1;
      end else begin
         if (stallreq_if === 1'b0 && prev_sr === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check("if_pc", if_pc, mon_e.pc);
               check("if_inst", if_inst, mon_e.inst);
               n_presented++;
            end
         end else if (stallreq_if === 1'b1) begin
            check("bubble_inst", if_inst, 32'd0);
            check("bubble_pc", if_pc, 32'd0);
         end
         prev_sr = stallreq_if;
      end
   end

   logic w_prev_sr = 1'b1;
   exp_t w_e;

   always @(negedge clk) begin
      if (!w_rst_n) begin
         w_prev_sr = 1'b1;
      end else begin
         if (w_stallreq === 1'b0 && w_prev_sr === 1'b1) begin
            if (w_q.size() == 0) begin
               check("wrap_sb_underflow", 32'd1, 32'd0);
            end else begin
               w_e = w_q.pop_front();
               check("wrap_if_pc", w_pc, w_e.pc);
               check("wrap_if_inst", w_inst, w_e.inst);
               // free-running: consumed on the next edge
               w_q.push_back(mk(w_e.pc + 32'd4));
            end
         end
         w_prev_sr = w_stallreq;
      end
   end

   // ---------------- driver helpers ----------------
   // Drive one cycle of decode-side inputs and advance the PC model.
   task automatic cyc(input bit r, input bit s1, input bit u, input logic [31:0] npc);
      rdy      = r;
      stall    = 5'($urandom);
      stall[1] = s1;
      use_npc  = u;
      npc_addr = npc;
      if (r && rst_n) begin
         if (u && !s1) begin
            if (stallreq_if && sb_q.size() > 0) void'(sb_q.pop_back());
            model_pc = npc;
            sb_q.push_back(mk(npc));
         end else if (!s1 && !stallreq_if) begin
            model_pc = model_pc + 32'd4;
            sb_q.push_back(mk(model_pc));
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_done(input bit s1);
      for (int i = 0; i < 300; i++) begin
         if (!stallreq_if) return;
         cyc(1'b1, s1, 1'b0, 32'd0);
      end
      check("wait_done_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_grants(input int n);
      for (int i = 0; i < 300; i++) begin
         if (grant_log.size() >= n) return;
         cyc(1'b1, 1'b0, 1'b0, 32'd0);
      end
      check("wait_grant_timeout", 32'd1, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_req"},  {31'd0, bus.mem_req}, 32'd0);
      check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
      check({tag, "_if_pc"},    if_pc, 32'd0);
      check({tag, "_if_inst"},  if_inst, 32'd0);
      check({tag, "_stallreq"}, {31'd0, stallreq_if}, 32'd1);
   endtask

   // watchdog
   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- main sequence ----------------
   logic [31:0] r_npc;

   initial begin
      rst_n = 1'b0; w_rst_n = 1'b0;
      rdy = 1'b1; stall = 5'b00010; use_npc = 1'b0; npc_addr = 32'd0;
      model_pc = 32'd0;
      #3;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      sb_q.push_back(mk(32'd0));
      w_q.push_back(mk(32'hFFFF_FFFC));
      rst_n = 1'b1; w_rst_n = 1'b1;

      // first fetch, IF/ID holding
      wait_done(1'b1);
      check("first_inst", if_inst, 32'h0010_0513);
      check("first_grants", grant_log.size(), 32'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check("first_addr", grant_log[i], 32'(i));

      // hold in DONE for 5 cycles
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'd0);
         check("hold_inst", if_inst, 32'h0010_0513);
         check("hold_pc", if_pc, 32'd0);
         check("hold_no_req", {31'd0, bus.mem_req}, 32'd0);
      end
      grant_log.delete();
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      wait_grants(1);
      check("after_hold_addr", grant_log[0], 32'd4);

      // redirect while byte 2 is outstanding (slow memory)
      fixed_lat = 3;
      wait_grants(3);
      grant_log.delete();
      cyc(1'b1, 1'b0, 1'b1, 32'h0000_0100);
      wait_grants(1);
      check("redirect_addr", grant_log[0], 32'h0000_0100);

      // redirect in DONE beats consume
      wait_done(1'b0);
      cyc(1'b1, 1'b0, 1'b1, 32'h0000_0200);
      check("redir_done_inst", if_inst, 32'd0);
      check("redir_done_stallreq", {31'd0, stallreq_if}, 32'd1);
      wait_done(1'b1);
      cyc(1'b1, 1'b0, 1'b0, 32'd0);

      // freeze with rdy=0 and junk returns mid-fetch
      fixed_lat = 1;
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'($urandom), 32'h0000_0300);
         check("freeze_stallreq", {31'd0, stallreq_if}, 32'd1);
      end
      wait_done(1'b1);
      cyc(1'b1, 1'b0, 1'b0, 32'd0);

      // asynchronous reset mid-cycle while byte 1 is in flight
      grant_log.delete();
      wait_grants(2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      sb_q.delete();
      sb_q.push_back(mk(32'd0));
      model_pc = 32'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_done(1'b1);
      cyc(1'b1, 1'b0, 1'b0, 32'd0);

      // randomized traffic
      rand_mode = 1;
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(3, 0))
            0:       r_npc = 32'hFFFF_FFFC + 32'($urandom_range(3, 0));
            1:       r_npc = 32'($urandom_range(255, 0));
            default: r_npc = $urandom;
         endcase
         cyc($urandom_range(9, 0) != 0, $urandom_range(3, 0) == 0,
             $urandom_range(19, 0) == 0, r_npc);
      end
      rand_mode = 0;
      wait_done(1'b1);
      cyc(1'b1, 1'b1, 1'b0, 32'd0);

      check("presented_enough", {31'd0, n_presented >= 20}, 32'd1);
      check("wrap_grants", {31'd0, w_log.size() >= 5}, 32'd1);
      if (w_log.size() >= 5) begin
         check("wrap_addr0", w_log[0], 32'hFFFF_FFFC);
         check("wrap_addr1", w_log[1], 32'hFFFF_FFFD);
         check("wrap_addr2", w_log[2], 32'hFFFF_FFFE);
         check("wrap_addr3", w_log[3], 32'hFFFF_FFFF);
         check("wrap_addr4", w_log[4], 32'h0000_0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_if_fetch

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the architectural PC and assembles 32-bit instructions from four little-endian byte reads over the byte-wide memory-controller port.
- Presents `if_pc`/`if_inst` for IF/ID to latch.
- Takes branch/jump redirects (`use_npc`/`npc_addr`) from the decode stage.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- rdy  in  1  global ready; 0 freezes all state
- stall  in  5  pipeline stall vector; stall[1]=1 means IF/ID holds (no consume)
- use_npc  in  1  redirect request from decode
- npc_addr  in  32  redirect target
- mem_req  out  1  byte read request
- mem_addr  out  32  byte address of request
- mem_gnt  in  1  arbiter accepts request this cycle
- mem_valid  in  1  requested byte returned this cycle
- mem_rdata  in  8  returned byte
- stallreq_if  out  1  fetch not yet complete
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  presented instruction; 32'h0 = bubble

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=FETCH, byte index k=0, no outstanding request, drain=0.
  - Outputs: mem_req=0, mem_addr=0, if_pc=0, if_inst=0, stallreq_if=1.
- rdy=0: every register holds; mem_valid/mem_gnt ignored; outputs hold.
- States:
  - FETCH: issues/awaits bytes k=0..3.
  - DONE: holds the assembled word.
- FETCH, issuing:
  - With no request outstanding, mem_req=1 and mem_addr=pc+k (32-bit add, wraps).
  - mem_gnt=1 marks the request outstanding; mem_req drops the next cycle.
  - Only one byte is outstanding at a time.
- FETCH, byte return:
  - On mem_valid, byte k is written to buf[8k+7:8k] and k increments.
  - When the k=3 byte returns, next state is DONE.
- Output timing:
  - FETCH: if_inst=0, if_pc=0, stallreq_if=1.
  - DONE: if_inst=buf, if_pc=pc, stallreq_if=0. Registered, so the first DONE cycle is the cycle after the 4th mem_valid.
- Consume:
  - In DONE with stall[1]=0 and use_npc=0: pc<=pc+4 (0xFFFFFFFC wraps to 0), k<=0, state<=FETCH.
  - In DONE with stall[1]=1: hold everything.
- Redirect:
  - Condition: use_npc=1 and stall[1]=0. Applies in any state and has priority over consume.
  - Action: pc<=npc_addr, k<=0, buf cleared, state<=FETCH.
  - With stall[1]=1, use_npc is ignored (decode re-asserts it).
- Redirect with a request outstanding (granted, not yet returned):
  - Set drain=1. The next mem_valid is discarded and clears drain.
  - mem_req stays 0 until drain=0.
- Redirect and mem_valid in the same cycle: the byte is discarded; drain is not set.
- Redirect while mem_req=1 and mem_gnt=1 in the same cycle: the request counts as outstanding and drain=1.
- npc_addr[1:0]≠0: no alignment check; bytes are fetched from npc_addr+k as given.
- mem_valid with no outstanding request: ignored.
- Reset mid-fetch: immediate return to reset values. The memory controller is reset concurrently, so no drain is needed.

Test Plan:
- Reset then fetch, memory bytes 0x13,0x05,0x10,0x00 at 0x0..0x3 with 1-cycle latency:
  - mem_addr sequence 0,1,2,3.
  - Then if_inst=32'h00100513, if_pc=0, stallreq_if=0.
  - Next fetch starts at 0x4.
- Hold: stall[1]=1 for 5 cycles in DONE:
  - if_inst/if_pc stable, no mem_req.
  - After release, pc=4 and mem_addr=0x4.
- Redirect mid-fetch: use_npc=1, npc_addr=0x100 while byte 2 at 0x2 is outstanding:
  - That byte is discarded.
  - Next mem_addr=0x100; assembled if_pc=0x100.
- Redirect in DONE, same cycle as a would-be consume:
  - pc=0x200 (not pc+4); buf cleared; if_inst=0 until the new fetch completes.
- rdy=0 for 3 cycles during FETCH with mem_valid pulsed:
  - No state change, byte ignored, k unchanged.
- Wrap: RESET_PC=0xFFFFFFFC:
  - Bytes fetched at 0xFFFFFFFC..0xFFFFFFFF.
  - After consume, next mem_addr=0x00000000.
- Async reset asserted mid-cycle during byte 1: outputs reach reset values before the next clock edge.
